// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module  : serial_frame_tx
//  Brief   : Port-addressed serial frame transmitter. Sends start bit, 2-bit
//            port, CNT_W-bit count, then the payload MSB first on SerOut.
//  Revision: 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int CNT_W     = 5,
    parameter int PAYLOAD_W = (1 << CNT_W) - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clkEN,
    input  logic                 start,
    input  logic [1:0]           port_sel,
    input  logic [CNT_W-1:0]     len,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 SerOut,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_PORT  = 3'd2;
    localparam logic [2:0] c_S_COUNT = 3'd3;
    localparam logic [2:0] c_S_DATA  = 3'd4;

    localparam logic [CNT_W-1:0] c_CNT_TOP = CNT_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_ser;
    logic                 w_ser_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     w_cnt_dec;
    logic [CNT_W-1:0]     w_len_dec;
    logic [CNT_W-1:0]     r_len_sh;
    logic [CNT_W-1:0]     w_len_sh_nxt;
    logic                 w_load;

    // Shadow copies keep the frame in flight independent of the live inputs.
    logic [1:0]           r_port;
    logic [CNT_W-1:0]     r_len;
    logic [PAYLOAD_W-1:0] r_payload;

    assign w_cnt_dec = r_cnt - c_CNT_ONE;
    assign w_len_dec = r_len - c_CNT_ONE;

    always_comb begin
        w_state_nxt  = r_state;
        w_ser_nxt    = r_ser;
        w_cnt_nxt    = r_cnt;
        w_len_sh_nxt = r_len_sh;
        w_load       = 1'b0;
        w_done_nxt   = 1'b0;
        if (clkEN) begin
            case (r_state)
                c_S_IDLE: begin
                    w_ser_nxt = 1'b1;
                    if (start) begin
                        w_load       = 1'b1;
                        w_ser_nxt    = 1'b0;
                        w_len_sh_nxt = len;
                        w_state_nxt  = c_S_START;
                    end
                end
                c_S_START: begin
                    w_ser_nxt   = r_port[1];
                    w_cnt_nxt   = c_CNT_ONE;
                    w_state_nxt = c_S_PORT;
                end
                c_S_PORT: begin
                    if (r_cnt != '0) begin
                        w_ser_nxt = r_port[0];
                        w_cnt_nxt = '0;
                    end else begin
                        w_ser_nxt    = r_len_sh[CNT_W-1];
                        w_len_sh_nxt = {r_len_sh[CNT_W-2:0], 1'b0};
                        w_cnt_nxt    = c_CNT_TOP;
                        w_state_nxt  = c_S_COUNT;
                    end
                end
                c_S_COUNT: begin
                    // r_cnt counts slots remaining after the one on the line.
                    if (r_cnt != '0) begin
                        w_ser_nxt    = r_len_sh[CNT_W-1];
                        w_len_sh_nxt = {r_len_sh[CNT_W-2:0], 1'b0};
                        w_cnt_nxt    = w_cnt_dec;
                    end else if (r_len != '0) begin
                        w_ser_nxt   = r_payload[w_len_dec];
                        w_cnt_nxt   = w_len_dec;
                        w_state_nxt = c_S_DATA;
                    end else begin
                        w_ser_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end
                end
                c_S_DATA: begin
                    if (r_cnt != '0) begin
                        w_ser_nxt = r_payload[w_cnt_dec];
                        w_cnt_nxt = w_cnt_dec;
                    end else begin
                        w_ser_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end
                end
                default: begin
                    w_ser_nxt   = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_ser     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_len_sh  <= '0;
            r_port    <= '0;
            r_len     <= '0;
            r_payload <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ser    <= w_ser_nxt;
            r_busy   <= (w_state_nxt != c_S_IDLE);
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len_sh <= w_len_sh_nxt;
            if (w_load) begin
                r_port    <= port_sel;
                r_len     <= len;
                r_payload <= payload;
            end
        end
    end

    assign SerOut = r_ser;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_serial_frame_tx
//  Brief   : Directed scoreboard bench for serial_frame_tx.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clkEN = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  port_sel = 2'b00;
    logic [4:0]  len = 5'd0;
    logic [30:0] payload = 31'd0;
    logic        SerOut;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cycles = 0;
    logic q[$];

    serial_frame_tx #(.CNT_W(5), .PAYLOAD_W(31)) dut (
        .clk      (clk),
        .reset    (reset),
        .clkEN    (clkEN),
        .start    (start),
        .port_sel (port_sel),
        .len      (len),
        .payload  (payload),
        .SerOut   (SerOut),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cycles++;
    end

    task automatic tick(input logic en);
        @(negedge clk);
        clkEN = en;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame with clkEN active one clock in `period`; optionally
    // keeps start high, scrambles inputs mid-frame, or resets at slot abort_slot.
    task automatic send_frame(input logic [1:0] p, input logic [4:0] l,
                              input logic [30:0] pl, input int period,
                              input bit hold, input bit scramble, input int abort_slot);
        int  n;
        int  d0;
        logic e;
        logic last;
        q.push_back(1'b0);
        q.push_back(p[1]);
        q.push_back(p[0]);
        for (int i = 4; i >= 0; i--) q.push_back(l[i]);
        for (int i = int'(l) - 1; i >= 0; i--) q.push_back(pl[i]);
        n = q.size();
        port_sel = p;
        len = l;
        payload = pl;
        start = 1'b1;
        d0 = done_cnt;
        busy_cycles = 0;
        last = 1'b1;
        for (int s = 0; s < n; s++) begin
            for (int k = 1; k < period; k++) begin
                tick(1'b0);
                chk("hold_serout", {31'd0, SerOut}, {31'd0, last});
                chk("hold_busy", {31'd0, busy}, {31'd0, (s != 0)});
            end
            tick(1'b1);
            if (s == 0 && !hold) start = 1'b0;
            if (s == 10 && scramble) begin
                port_sel = ~p;
                len = ~l;
                payload = ~pl;
            end
            e = q.pop_front();
            last = e;
            chk($sformatf("slot%0d", s), {31'd0, SerOut}, {31'd0, e});
            chk("busy_in_frame", {31'd0, busy}, 32'd1);
            if (abort_slot != 0 && s == abort_slot - 1) begin
                start = 1'b0;
                #2 reset = 1'b1;
                #1;
                chk("abort_serout", {31'd0, SerOut}, 32'd1);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                tick(1'b1);
                tick(1'b1);
                chk("abort_no_done", done_cnt, d0);
                @(negedge clk) reset = 1'b0;
                q.delete();
                return;
            end
        end
        for (int k = 1; k < period; k++) tick(1'b0);
        tick(1'b1);
        chk("end_serout", {31'd0, SerOut}, 32'd1);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_done", {31'd0, done}, 32'd1);
        tick(1'b0);
        chk("done_one_clk", {31'd0, done}, 32'd0);
        chk("done_count", done_cnt, d0 + 1);
        chk("busy_cycles", busy_cycles, n * period);
    endtask

    initial begin
        // Reset and idle
        repeat (3) tick(1'b1);
        chk("reset_serout", {31'd0, SerOut}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            chk("idle_serout", {31'd0, SerOut}, 32'd1);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd0);
        end

        // Basic frame to port 2, three payload bits
        send_frame(2'b10, 5'd3, 31'b101, 1, 1'b0, 1'b0, 0);
        tick(1'b1);

        // Empty payload
        send_frame(2'b01, 5'd0, 31'h1234_5678, 1, 1'b0, 1'b0, 0);
        tick(1'b1);

        // Maximum payload, sparse strobe, inputs disturbed mid-frame
        send_frame(2'b01, 5'd31, 31'h7FFF_FFFF, 4, 1'b0, 1'b1, 0);
        tick(1'b1);

        // Back-to-back frames with start held high
        send_frame(2'b00, 5'd4, 31'hA, 1, 1'b1, 1'b0, 0);
        send_frame(2'b11, 5'd7, 31'h5B, 1, 1'b0, 1'b0, 0);
        tick(1'b1);

        // Reset during the fifth data slot, then a fresh frame
        send_frame(2'b10, 5'd10, 31'h2A5, 1, 1'b0, 1'b0, 13);
        tick(1'b1);
        chk("post_abort_idle", {31'd0, SerOut}, 32'd1);
        send_frame(2'b01, 5'd6, 31'h2D, 2, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
